router_register: RTL and testbench

Datapath register stage of the 1x3 router, directly downstream of the router FSM controller. Driven by the controller's one-hot state strobes, it latches the header byte, streams payload bytes to the output FIFOs, holds a byte captured while a FIFO is full, and accumulates parity. It returns `parity_done`, `low_pkt_valid` and `err` to the controller and status logic.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_register_if.sv | 31 +++
 rtl/router_parity_checker.sv | 59 +++++
 rtl/router_register.sv | 95 +++++++++
 tb/tb_router_register.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: byte width, reserved address and
// the controller state encoding used by both controller and datapath.
package router_pkg;

  localparam int unsigned DATA_WIDTH   = 8;
  localparam logic [1:0]  ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_e;

  // A header addresses one of the three output FIFOs; 2'b11 is reserved.
  function automatic logic addr_is_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_register_if.sv
// Controller/source side to datapath register stage: state strobes, source
// byte stream, FIFO full flag and the registered status returned upstream.
interface router_register_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_addr;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_parity_checker.sv
// Running XOR parity over header and payload, captured parity byte, and the
// registered mismatch flag sampled when the controller checks parity.
module router_parity_checker
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hdr_capture,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] hdr_byte,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic                  err_q, err_d;

  // Next-state for parity accumulator, captured parity byte and error flag.
  // full_state never accumulates, even if it were to coincide with a load.
  always_comb begin
    int_parity_d = int_parity_q;
    pkt_parity_d = pkt_parity_q;
    err_d        = err_q;
    if (hdr_capture) begin
      int_parity_d = '0;
      err_d        = 1'b0;
    end else if (lfd_state) begin
      int_parity_d = int_parity_q ^ hdr_byte;
    end else if (ld_state && !full_state) begin
      if (pkt_valid) int_parity_d = int_parity_q ^ data_in;
      else           pkt_parity_d = data_in;
    end else if (rst_int_reg) begin
      err_d = (int_parity_q != pkt_parity_q);
    end
  end

  // Parity state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      err_q        <= 1'b0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/router_register.sv
// Router datapath register stage: latches the header, streams payload to the
// output FIFO, parks a byte while the FIFO is full and flags parity status.
module router_register
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  router_register_if.slave bus
);

  logic [DATA_WIDTH-1:0] hdr_byte_q, hdr_byte_d;
  logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;
  logic                  hdr_capture;

  assign hdr_capture = bus.detect_addr && bus.pkt_valid && addr_is_valid(bus.data_in[1:0]);

  // Next-state for header, parked byte, output byte and status flags.
  always_comb begin
    hdr_byte_d      = hdr_byte_q;
    full_byte_d     = full_byte_q;
    dout_d          = dout_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;

    if (hdr_capture) begin
      hdr_byte_d      = bus.data_in;
      parity_done_d   = 1'b0;
      low_pkt_valid_d = 1'b0;
    end

    if (bus.lfd_state) begin
      dout_d = hdr_byte_q;
    end else if (bus.ld_state) begin
      if (bus.fifo_full) full_byte_d = bus.data_in;
      else               dout_d      = bus.data_in;
    end else if (bus.laf_state) begin
      dout_d = full_byte_q;
    end

    if (bus.ld_state && !bus.pkt_valid) low_pkt_valid_d = 1'b1;
    else if (bus.rst_int_reg)          low_pkt_valid_d = 1'b0;

    if ((bus.ld_state && !bus.pkt_valid && !bus.fifo_full) ||
        (bus.laf_state && low_pkt_valid_q && !parity_done_q))
      parity_done_d = 1'b1;
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_byte_q      <= '0;
      full_byte_q     <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      hdr_byte_q      <= hdr_byte_d;
      full_byte_q     <= full_byte_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  router_parity_checker #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .clk         (clk),
    .rst         (rst),
    .hdr_capture (hdr_capture),
    .lfd_state   (bus.lfd_state),
    .ld_state    (bus.ld_state),
    .full_state  (bus.full_state),
    .rst_int_reg (bus.rst_int_reg),
    .pkt_valid   (bus.pkt_valid),
    .hdr_byte    (hdr_byte_q),
    .data_in     (bus.data_in),
    .err         (bus.err)
  );

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;

  // Controller strobes are one-hot by construction.
  a_strobes_onehot0 : assert property (@(posedge clk) disable iff (!rst)
    $onehot0({bus.detect_addr, bus.lfd_state, bus.ld_state,
              bus.laf_state, bus.full_state, bus.rst_int_reg}));

endmodule

// File: tb/tb_router_register.sv
// Directed bench for router_register: good/bad packets, full-FIFO handling,
// reserved address and asynchronous reset.
module tb_router_register;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DET  = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RIR  = 6'b000001;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  router_register_if #(.DATA_WIDTH(8)) bus ();

  router_register #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic [5:0] s, input logic pv, input logic [7:0] din, input logic ff);
    {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state, bus.rst_int_reg} = s;
    bus.pkt_valid = pv;
    bus.data_in   = din;
    bus.fifo_full = ff;
    @(posedge clk);
    #1;
    {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state, bus.rst_int_reg} = S_NONE;
    bus.pkt_valid = 1'b0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state, bus.rst_int_reg} = S_NONE;
    bus.pkt_valid = 1'b0;
    bus.data_in   = 8'h00;
    bus.fifo_full = 1'b0;
    #3;
    total++; if (bus.dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", bus.dout); else passed++;
    total++; if ({bus.parity_done, bus.low_pkt_valid, bus.err} !== 3'b000)
      $display("FAIL reset_flags got=%b exp=000", {bus.parity_done, bus.low_pkt_valid, bus.err}); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good_packet();
    step(S_DET, 1'b1, 8'h0D, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    total++; if (bus.dout !== 8'h0D) $display("FAIL good_hdr got=%h exp=0d", bus.dout); else passed++;
    step(S_LD, 1'b1, 8'h11, 1'b0);
    total++; if (bus.dout !== 8'h11) $display("FAIL good_p0 got=%h exp=11", bus.dout); else passed++;
    step(S_LD, 1'b1, 8'h22, 1'b0);
    total++; if (bus.dout !== 8'h22) $display("FAIL good_p1 got=%h exp=22", bus.dout); else passed++;
    step(S_LD, 1'b1, 8'h33, 1'b0);
    total++; if (bus.dout !== 8'h33) $display("FAIL good_p2 got=%h exp=33", bus.dout); else passed++;
    total++; if (bus.low_pkt_valid !== 1'b0) $display("FAIL good_lpv_early got=%b exp=0", bus.low_pkt_valid); else passed++;
    step(S_LD, 1'b0, 8'h0D, 1'b0);
    total++; if (bus.dout !== 8'h0D) $display("FAIL good_par got=%h exp=0d", bus.dout); else passed++;
    total++; if ({bus.parity_done, bus.low_pkt_valid} !== 2'b11)
      $display("FAIL good_pd_lpv got=%b exp=11", {bus.parity_done, bus.low_pkt_valid}); else passed++;
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    step(S_RIR, 1'b0, 8'h00, 1'b0);
    total++; if (bus.err !== 1'b0) $display("FAIL good_err got=%b exp=0", bus.err); else passed++;
    total++; if (bus.low_pkt_valid !== 1'b0) $display("FAIL good_lpv_clr got=%b exp=0", bus.low_pkt_valid); else passed++;
    total++; if (bus.parity_done !== 1'b1) $display("FAIL good_pd_hold got=%b exp=1", bus.parity_done); else passed++;
  endtask

  task automatic test_bad_parity();
    step(S_DET, 1'b1, 8'h0D, 1'b0);
    total++; if ({bus.parity_done, bus.err} !== 2'b00)
      $display("FAIL bad_hdr_clr got=%b exp=00", {bus.parity_done, bus.err}); else passed++;
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    step(S_LD, 1'b1, 8'h11, 1'b0);
    step(S_LD, 1'b1, 8'h22, 1'b0);
    step(S_LD, 1'b1, 8'h33, 1'b0);
    step(S_LD, 1'b0, 8'h0C, 1'b0);
    total++; if (bus.dout !== 8'h0C) $display("FAIL bad_par_dout got=%h exp=0c", bus.dout); else passed++;
    step(S_RIR, 1'b0, 8'h00, 1'b0);
    total++; if (bus.err !== 1'b1) $display("FAIL bad_err got=%b exp=1", bus.err); else passed++;
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    step(S_NONE, 1'b0, 8'h00, 1'b0);
    total++; if (bus.err !== 1'b1) $display("FAIL bad_err_hold got=%b exp=1", bus.err); else passed++;
    // Reserved address: nothing may change.
    step(S_DET, 1'b1, 8'h07, 1'b0);
    total++; if (bus.dout !== 8'h0C) $display("FAIL inv_dout got=%h exp=0c", bus.dout); else passed++;
    total++; if ({bus.err, bus.parity_done} !== 2'b11)
      $display("FAIL inv_flags got=%b exp=11", {bus.err, bus.parity_done}); else passed++;
    step(S_LFD, 1'b0, 8'h00, 1'b0);
    total++; if (bus.dout !== 8'h0D) $display("FAIL inv_hdr_kept got=%h exp=0d", bus.dout); else passed++;
    step(S_DET, 1'b1, 8'h05, 1'b0);
    total++; if ({bus.err, bus.parity_done, bus.low_pkt_valid} !== 3'b000)
      $display("FAIL hdr05_clr got=%b exp=000", {bus.err, bus.parity_done, bus.low_pkt_valid}); else passed++;
    step(S_LFD, 1'b1, 8'h00, 1'b0);
    total++; if (bus.dout !== 8'h05) $display("FAIL hdr05_dout got=%h exp=05", bus.dout); else passed++;
  endtask

  task automatic test_full_mid_payload();
    step(S_DET, 1'b1, 8'h05, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    step(S_LD, 1'b1, 8'h11, 1'b0);
    step(S_LD, 1'b1, 8'h44, 1'b1);
    total++; if (bus.dout !== 8'h11) $display("FAIL full_hold got=%h exp=11", bus.dout); else passed++;
    step(S_FULL, 1'b1, 8'h44, 1'b1);
    total++; if (bus.dout !== 8'h11) $display("FAIL full_state_hold got=%h exp=11", bus.dout); else passed++;
    step(S_LAF, 1'b1, 8'h55, 1'b0);
    total++; if (bus.dout !== 8'h44) $display("FAIL laf_dout got=%h exp=44", bus.dout); else passed++;
    step(S_LD, 1'b1, 8'h55, 1'b0);
    total++; if (bus.dout !== 8'h55) $display("FAIL after_full got=%h exp=55", bus.dout); else passed++;
    // 05 ^ 11 ^ 44 ^ 55 = 05
    step(S_LD, 1'b0, 8'h05, 1'b0);
    step(S_RIR, 1'b0, 8'h00, 1'b0);
    total++; if (bus.err !== 1'b0) $display("FAIL full_err got=%b exp=0", bus.err); else passed++;
  endtask

  task automatic test_parity_while_full();
    step(S_DET, 1'b1, 8'h0E, 1'b0);
    step(S_LFD, 1'b1, 8'h20, 1'b0);
    step(S_LD, 1'b1, 8'h20, 1'b0);
    step(S_LD, 1'b0, 8'h2E, 1'b1);
    total++; if ({bus.low_pkt_valid, bus.parity_done} !== 2'b10)
      $display("FAIL pfull_flags got=%b exp=10", {bus.low_pkt_valid, bus.parity_done}); else passed++;
    total++; if (bus.dout !== 8'h20) $display("FAIL pfull_hold got=%h exp=20", bus.dout); else passed++;
    step(S_FULL, 1'b0, 8'h00, 1'b1);
    total++; if (bus.parity_done !== 1'b0) $display("FAIL pfull_fs_pd got=%b exp=0", bus.parity_done); else passed++;
    step(S_LAF, 1'b0, 8'h00, 1'b0);
    total++; if (bus.dout !== 8'h2E) $display("FAIL pfull_laf_dout got=%h exp=2e", bus.dout); else passed++;
    total++; if (bus.parity_done !== 1'b1) $display("FAIL pfull_laf_pd got=%b exp=1", bus.parity_done); else passed++;
    step(S_RIR, 1'b0, 8'h00, 1'b0);
    total++; if ({bus.err, bus.low_pkt_valid} !== 2'b00)
      $display("FAIL pfull_err got=%b exp=00", {bus.err, bus.low_pkt_valid}); else passed++;
  endtask

  task automatic test_async_reset_mid_payload();
    step(S_DET, 1'b1, 8'h0D, 1'b0);
    step(S_LFD, 1'b1, 8'h11, 1'b0);
    step(S_LD, 1'b1, 8'h11, 1'b0);
    step(S_LD, 1'b0, 8'h22, 1'b0);
    total++; if ({bus.dout, bus.parity_done, bus.low_pkt_valid} !== {8'h22, 2'b11})
      $display("FAIL arst_pre got=%h/%b%b exp=22/11", bus.dout, bus.parity_done, bus.low_pkt_valid); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (bus.dout !== 8'h00) $display("FAIL arst_dout got=%h exp=00", bus.dout); else passed++;
    total++; if ({bus.err, bus.parity_done, bus.low_pkt_valid} !== 3'b000)
      $display("FAIL arst_flags got=%b exp=000", {bus.err, bus.parity_done, bus.low_pkt_valid}); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    step(S_LFD, 1'b0, 8'h00, 1'b0);
    total++; if (bus.dout !== 8'h00) $display("FAIL arst_hdr_clr got=%h exp=00", bus.dout); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_full_mid_payload();
    test_parity_while_full();
    test_async_reset_mid_payload();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
